demux_memoria1x4_4bits: RTL



---
 rtl/demux_mem_pkg.sv | 16 +
 rtl/demux_lane_reg.sv | 33 +++
 rtl/demux_memoria1x4_4bits.sv | 106 ++++++++++
 3 files changed

// File: rtl/demux_mem_pkg.sv
// Shared constants for the 1x4 memory demultiplexer.
//   DATA_W       : width of each data word and each output lane
//   LANES        : number of output lanes (fixed at 4)
//   SEL_W        : width of the lane selector / round-robin pointer
//   SEL_MODE_RR  : sel_mode value selecting the internal round-robin pointer
//   SEL_MODE_EXT : sel_mode value selecting the external selector
package demux_mem_pkg;

  localparam int DATA_W = 4;
  localparam int LANES  = 4;
  localparam int SEL_W  = 2;

  localparam logic SEL_MODE_RR  = 1'b0;
  localparam logic SEL_MODE_EXT = 1'b1;

endpackage

// File: rtl/demux_lane_reg.sv
// One output lane of the demultiplexer: a data register loaded on wr_en and
// a valid flop that pulses for exactly one cycle after each write.
// Ports:
//   clk     : rising-edge clock
//   reset_L : asynchronous active-low clear of data and valid
//   wr_en   : load din at this edge
//   din     : word to store
//   dout    : stored word, held between writes
//   vld     : high for the cycle following a write
module demux_lane_reg
  import demux_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              vld
);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      dout <= '0;
      vld  <= 1'b0;
    end else begin
      vld <= wr_en;
      if (wr_en) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/demux_memoria1x4_4bits.sv
// Receive-side 1x4 memory demultiplexer. Each accepted word is written to one
// of four registered lanes; lanes hold their value and pulse their own valid.
// In round-robin mode an internal pointer walks lanes 0..3 and group_valid
// flags a completed 4-word group; in external mode selector4x1 steers words.
// Ports:
//   clk          : rising-edge clock
//   reset_L      : asynchronous active-low reset
//   valid_input  : data_in carries a word this cycle
//   data_in      : incoming word
//   sel_mode     : 0 = round-robin pointer, 1 = external selector
//   selector4x1  : destination lane in external mode
//   data_out0..3 : lane data, held between writes
//   valid_out0..3: one-cycle pulse after the lane is written
//   group_valid  : one-cycle pulse alongside valid_out3 closing a full group
//   lane_ptr     : next lane to be written in round-robin mode
module demux_memoria1x4_4bits
  import demux_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_L,
  input  logic              valid_input,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sel_mode,
  input  logic [SEL_W-1:0]  selector4x1,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              valid_out2,
  output logic              valid_out3,
  output logic              group_valid,
  output logic [SEL_W-1:0]  lane_ptr
);

  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);

  logic [SEL_W-1:0]  lane;
  logic [LANES-1:0]  wr_en;
  // Progress flags for lanes 0..2; lane 3 closes the group and never needs one.
  logic [LANES-2:0]  rr_flags;
  logic [DATA_W-1:0] dout_a [LANES];
  logic [LANES-1:0]  vld_a;

  assign lane = (sel_mode == SEL_MODE_EXT) ? selector4x1 : lane_ptr;

  always_comb begin
    wr_en = '0;
    if (valid_input) begin
      wr_en[lane] = 1'b1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_lane_reg u_lane (
      .clk     (clk),
      .reset_L (reset_L),
      .wr_en   (wr_en[i]),
      .din     (data_in),
      .dout    (dout_a[i]),
      .vld     (vld_a[i])
    );
  end

  assign data_out0  = dout_a[0];
  assign data_out1  = dout_a[1];
  assign data_out2  = dout_a[2];
  assign data_out3  = dout_a[3];
  assign valid_out0 = vld_a[0];
  assign valid_out1 = vld_a[1];
  assign valid_out2 = vld_a[2];
  assign valid_out3 = vld_a[3];

  // Round-robin pointer, group progress and group completion pulse.
  // External mode parks the pointer at lane 0 so round-robin always restarts
  // a fresh group; idle cycles leave pointer and flags untouched so gaps in
  // the stream never break a group.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      lane_ptr    <= '0;
      rr_flags    <= '0;
      group_valid <= 1'b0;
    end else if (sel_mode == SEL_MODE_EXT) begin
      lane_ptr    <= '0;
      rr_flags    <= '0;
      group_valid <= 1'b0;
    end else if (valid_input) begin
      lane_ptr <= lane_ptr + 1'b1;
      if (lane == LAST_LANE) begin
        group_valid <= &rr_flags;
        rr_flags    <= '0;
      end else begin
        group_valid <= 1'b0;
        for (int i = 0; i < LANES - 1; i++) begin
          if (lane == SEL_W'(i)) begin
            rr_flags[i] <= 1'b1;
          end
        end
      end
    end else begin
      group_valid <= 1'b0;
    end
  end

endmodule
